// File: rtl/pc_redirect_ctrl.sv
// Turns the EX-stage resolver result into a single PC redirect for fetch,
// flushes younger stages, flags misaligned targets and keeps branch statistics.
module pc_redirect_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_stall,
  input  logic        ex_is_branch,
  input  logic        ex_is_jump,
  input  logic        ex_modify_pc,
  input  logic [31:0] ex_update_pc,
  input  logic        if_stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        misalign_exc,
  output logic [31:0] branch_cnt,
  output logic [31:0] taken_cnt
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PENDING = 1'b1;

  logic [0:0]  state;
  logic [0:0]  state_next;
  logic [31:0] pending_pc;
  logic        fired;
  logic        req;
  logic        mis;
  logic        accepted;
  logic        capture;
  logic        branch_event;

  assign req      = ex_valid & ex_modify_pc & ~fired;
  assign mis      = req & (ex_update_pc[1:0] != 2'b00);
  assign accepted = (state == IDLE) & req;
  assign capture  = accepted & ~mis & if_stall;

  // A decoder never flags both; excluding jumps keeps JAL/JALR out of the stats.
  assign branch_event = ex_valid & ex_is_branch & ~ex_is_jump & ~ex_stall;

  always_comb begin
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    flush_if_id    = 1'b0;
    flush_id_ex    = 1'b0;
    misalign_exc   = 1'b0;
    state_next     = state;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (req) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            if (mis) begin
              misalign_exc = 1'b1;
            end else if (!if_stall) begin
              redirect_valid = 1'b1;
              redirect_pc    = ex_update_pc;
            end else begin
              state_next = PENDING;
            end
          end
        end
        PENDING: begin
          redirect_valid = 1'b1;
          redirect_pc    = pending_pc;
          flush_if_id    = 1'b1;
          if (!if_stall) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // fired remembers an already-acted-on request while EX holds the same instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pending_pc <= 32'h0;
      fired      <= 1'b0;
      branch_cnt <= 32'h0;
      taken_cnt  <= 32'h0;
    end else begin
      state <= state_next;
      fired <= ex_stall & (fired | accepted);
      if (capture) pending_pc <= ex_update_pc;
      if (branch_event) begin
        branch_cnt <= branch_cnt + 32'd1;
        if (ex_modify_pc) taken_cnt <= taken_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed self-checking bench for pc_redirect_ctrl: redirects, stalls,
// misalignment, counters with wrap, and asynchronous reset in PENDING.
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_stall, ex_is_branch, ex_is_jump, ex_modify_pc;
  logic [31:0] ex_update_pc;
  logic        if_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_if_id, flush_id_ex, misalign_exc;
  logic [31:0] branch_cnt, taken_cnt;

  int checks   = 0;
  int failures = 0;

  pc_redirect_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_is_branch(ex_is_branch),
    .ex_is_jump(ex_is_jump), .ex_modify_pc(ex_modify_pc), .ex_update_pc(ex_update_pc),
    .if_stall(if_stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .misalign_exc(misalign_exc),
    .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkRedirect(input string tag, input logic rv, input logic [31:0] pc,
                               input logic fif, input logic fie, input logic mis);
    checkOutput({tag, ".redirect_valid"}, {31'h0, redirect_valid}, {31'h0, rv});
    checkOutput({tag, ".redirect_pc"}, redirect_pc, pc);
    checkOutput({tag, ".flush_if_id"}, {31'h0, flush_if_id}, {31'h0, fif});
    checkOutput({tag, ".flush_id_ex"}, {31'h0, flush_id_ex}, {31'h0, fie});
    checkOutput({tag, ".misalign_exc"}, {31'h0, misalign_exc}, {31'h0, mis});
  endtask

  task automatic applyStimulus(input logic v, input logic st, input logic br, input logic jp,
                               input logic md, input logic [31:0] pc, input logic ifs);
    ex_valid     = v;
    ex_stall     = st;
    ex_is_branch = br;
    ex_is_jump   = jp;
    ex_modify_pc = md;
    ex_update_pc = pc;
    if_stall     = ifs;
  endtask

  // Drive a new cycle's inputs just after the falling edge, then sample 1ns later.
  task automatic cycle(input logic v, input logic st, input logic br, input logic jp,
                       input logic md, input logic [31:0] pc, input logic ifs);
    @(negedge clk);
    applyStimulus(v, st, br, jp, md, pc, ifs);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #2;
    checkRedirect("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset.branch_cnt", branch_cnt, 32'h0);
    checkOutput("reset.taken_cnt", taken_cnt, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain taken jump: same-cycle redirect.
    cycle(1, 0, 0, 1, 1, 32'h0000_0100, 0);
    checkRedirect("plain", 1'b1, 32'h100, 1'b1, 1'b1, 1'b0);
    cycle(0, 0, 0, 0, 0, 32'h0, 0);
    checkRedirect("plain_after", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Fetch stall for 3 cycles: capture, hold, consume.
    cycle(1, 0, 0, 1, 1, 32'h0000_0100, 1);
    checkRedirect("ifst0", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    cycle(0, 0, 0, 0, 0, 32'h0, 1);
    checkRedirect("ifst1", 1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
    cycle(0, 0, 0, 0, 0, 32'h0, 1);
    checkRedirect("ifst2", 1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
    cycle(0, 0, 0, 0, 0, 32'h0, 0);
    checkRedirect("ifst3", 1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
    cycle(0, 0, 0, 0, 0, 32'h0, 0);
    checkRedirect("ifst_idle", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // EX stall for 4 cycles: one redirect only, then fired clears.
    cycle(1, 1, 0, 1, 1, 32'h0000_0200, 0);
    checkRedirect("exst0", 1'b1, 32'h200, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i < 4; i++) begin
      cycle(1, 1, 0, 1, 1, 32'h0000_0200, 0);
      checkRedirect("exst_hold", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    end
    cycle(1, 0, 0, 1, 1, 32'h0000_0200, 0);
    checkRedirect("exst_done", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cycle(1, 0, 0, 1, 1, 32'h0000_0300, 0);
    checkRedirect("exst_next", 1'b1, 32'h300, 1'b1, 1'b1, 1'b0);

    // Misaligned target, unstalled and then stalled (single pulse).
    cycle(1, 0, 0, 1, 1, 32'h0000_0102, 0);
    checkRedirect("mis", 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    cycle(1, 1, 0, 1, 1, 32'h0000_0103, 0);
    checkRedirect("mis_st0", 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    cycle(1, 1, 0, 1, 1, 32'h0000_0103, 0);
    checkRedirect("mis_st1", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cycle(1, 0, 0, 1, 1, 32'h0000_0103, 0);
    checkRedirect("mis_st2", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // EX and fetch stalled together: capture, then exactly one redirect.
    cycle(1, 1, 0, 1, 1, 32'h0000_0400, 1);
    checkRedirect("both0", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    cycle(1, 1, 0, 1, 1, 32'h0000_0400, 0);
    checkRedirect("both1", 1'b1, 32'h400, 1'b1, 1'b0, 1'b0);
    cycle(1, 1, 0, 1, 1, 32'h0000_0400, 0);
    checkRedirect("both2", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cycle(1, 0, 0, 1, 1, 32'h0000_0400, 0);
    checkRedirect("both3", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Counters: 5 branches (3 taken), 2 jumps, one bubble, one stalled branch.
    cycle(1, 0, 1, 0, 1, 32'h0000_0010, 0);
    cycle(1, 0, 1, 0, 0, 32'h0, 0);
    cycle(1, 0, 0, 1, 1, 32'h0000_0020, 0);
    cycle(0, 0, 1, 0, 1, 32'h0000_0024, 0);
    cycle(1, 1, 1, 0, 1, 32'h0000_0030, 0);
    cycle(1, 0, 1, 0, 1, 32'h0000_0030, 0);
    cycle(1, 0, 1, 0, 0, 32'h0, 0);
    cycle(1, 0, 0, 1, 1, 32'h0000_0040, 0);
    cycle(1, 0, 1, 0, 1, 32'h0000_0050, 0);
    cycle(0, 0, 0, 0, 0, 32'h0, 0);
    checkOutput("cnt.branch_cnt", branch_cnt, 32'd5);
    checkOutput("cnt.taken_cnt", taken_cnt, 32'd3);

    // Wrap: preload counters near all-ones, then two taken branches.
    @(negedge clk);
    dut.branch_cnt = 32'hFFFF_FFFF;
    dut.taken_cnt  = 32'hFFFF_FFFE;
    applyStimulus(1, 0, 1, 0, 1, 32'h0000_0060, 0);
    #1;
    cycle(0, 0, 0, 0, 0, 32'h0, 0);
    checkOutput("wrap1.branch_cnt", branch_cnt, 32'h0);
    checkOutput("wrap1.taken_cnt", taken_cnt, 32'hFFFF_FFFF);
    cycle(1, 0, 1, 0, 1, 32'h0000_0070, 0);
    cycle(0, 0, 0, 0, 0, 32'h0, 0);
    checkOutput("wrap2.branch_cnt", branch_cnt, 32'h1);
    checkOutput("wrap2.taken_cnt", taken_cnt, 32'h0);

    // Reset while PENDING: outputs drop at once, nothing replays afterwards.
    cycle(1, 0, 0, 1, 1, 32'h0000_0500, 1);
    cycle(0, 0, 0, 0, 0, 32'h0, 1);
    checkRedirect("rstp_pend", 1'b1, 32'h500, 1'b1, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    applyStimulus(1, 0, 1, 0, 1, 32'h0000_0600, 0);
    #1;
    checkRedirect("rstp_in", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("rstp_in.branch_cnt", branch_cnt, 32'h0);
    checkOutput("rstp_in.taken_cnt", taken_cnt, 32'h0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 0);
    rst_n = 1'b1;
    #1;
    checkRedirect("rstp_rel0", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cycle(0, 0, 0, 0, 0, 32'h0, 0);
    checkRedirect("rstp_rel1", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cycle(0, 0, 0, 0, 0, 32'h0, 0);
    checkRedirect("rstp_rel2", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
